// File: rtl/pes_dff_arbiter.sv
// ---------------------------------------------------------------------------
// pes_dff_arbiter
//
// Round-robin arbiter and sequencer that shares one DATA_W-bit data register
// among NUM_REQ requesters. One requester owns the register at a time. The
// owner's data is loaded once per cycle for up to MAX_HOLD cycles, and then
// the grant is released. A one-cycle IDLE bubble always separates two grants.
//
// Optional feature (compile-time macro PES_DFF_ARB_LOCK_EN):
//   This macro adds the i_lock input. While i_lock is high, the hold limit is
//   suspended and the owner keeps the grant for as long as it requests.
//
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous active-low reset
//   i_req    - per-requester request level
//   i_data   - requester k data at [k*DATA_W +: DATA_W]
//   i_lock   - (PES_DFF_ARB_LOCK_EN only) suspend the hold limit for the owner
//   o_gnt    - one-hot grant, all zero when no owner
//   o_owner  - index of the current owner, or of the last owner while idle
//   o_q      - shared data register
//   o_qb     - complement of o_q
//   o_valid  - high for the cycle after each load of o_q
// ---------------------------------------------------------------------------
module pes_dff_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [NUM_REQ*DATA_W-1:0]    i_data,
`ifdef PES_DFF_ARB_LOCK_EN
    input  logic                         i_lock,
`endif
    output logic [NUM_REQ-1:0]           o_gnt,
    output logic [$clog2(NUM_REQ)-1:0]   o_owner,
    output logic [DATA_W-1:0]            o_q,
    output logic [DATA_W-1:0]            o_qb,
    output logic                         o_valid
);

    localparam int OW_W = $clog2(NUM_REQ);
    localparam int CW   = 8;

    localparam logic [CW-1:0]      HOLD_LAST = CW'(MAX_HOLD - 1);
    localparam logic [OW_W-1:0]    LAST_IDX  = OW_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] GNT_ONE   = NUM_REQ'(1);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t            state;
    logic [OW_W-1:0]   rr_ptr;
    logic [CW-1:0]     hold_cnt;

    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic [DATA_W-1:0] owner_data;
    logic              owner_req;
    logic              lock_on;
    logic [OW_W-1:0]   next_ptr;
    logic              pick_valid;
    logic [OW_W-1:0]   pick_idx;
    logic [OW_W-1:0]   cand;

    // Split the flat data bus into one slice per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign data_arr[g] = i_data[g*DATA_W +: DATA_W];
    end

    assign owner_data = data_arr[o_owner];
    assign owner_req  = i_req[o_owner];
    assign o_qb       = ~o_q;

`ifdef PES_DFF_ARB_LOCK_EN
    assign lock_on = i_lock;
`else
    assign lock_on = 1'b0;
`endif

    // Round-robin pointer after the current owner, wrapping at NUM_REQ-1.
    always_comb begin
        next_ptr = o_owner + 1'b1;
        if (o_owner == LAST_IDX) begin
            next_ptr = '0;
        end
    end

    // Scan circularly from rr_ptr. The first requester found wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = OW_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!pick_valid && i_req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            o_gnt    <= '0;
            o_owner  <= '0;
            o_q      <= '0;
            o_valid  <= 1'b0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= OWN;
                        o_gnt    <= GNT_ONE << pick_idx;
                        o_owner  <= pick_idx;
                        hold_cnt <= '0;
                    end
                end
                OWN: begin
                    if (owner_req) begin
                        o_q     <= owner_data;
                        o_valid <= 1'b1;
                        if (lock_on) begin
                            // While locked, the counter saturates at the last
                            // slot. This way the limit takes effect on the
                            // first cycle after the lock is released.
                            if (hold_cnt != HOLD_LAST) begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                            if (hold_cnt == HOLD_LAST) begin
                                state  <= IDLE;
                                o_gnt  <= '0;
                                rr_ptr <= next_ptr;
                            end
                        end
                    end else begin
                        state  <= IDLE;
                        o_gnt  <= '0;
                        rr_ptr <= next_ptr;
                    end
                end
                default: begin
                    state <= IDLE;
                    o_gnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pes_dff_arbiter.sv
module tb_pes_dff_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  i_req;
    logic [31:0] i_data;
`ifdef PES_DFF_ARB_LOCK_EN
    logic        i_lock;
`endif
    logic [3:0]  o_gnt;
    logic [1:0]  o_owner;
    logic [7:0]  o_q;
    logic [7:0]  o_qb;
    logic        o_valid;

    int checks;
    int failures;

    pes_dff_arbiter #(
        .NUM_REQ  (4),
        .DATA_W   (8),
        .MAX_HOLD (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_data  (i_data),
`ifdef PES_DFF_ARB_LOCK_EN
        .i_lock  (i_lock),
`endif
        .o_gnt   (o_gnt),
        .o_owner (o_owner),
        .o_q     (o_q),
        .o_qb    (o_qb),
        .o_valid (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset  = 1'b0;
        i_req  = 4'b0000;
        i_data = 32'h0;
`ifdef PES_DFF_ARB_LOCK_EN
        i_lock = 1'b0;
`endif
        tick;
        tick;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
`ifdef PES_DFF_ARB_LOCK_EN
        i_lock = 1'b0;
`endif
        for (int n = 0; n < 5; n++) begin
            if (n < 2) begin
                i_req  = 4'($urandom);
                i_data = 32'($urandom);
            end else begin
                reset = 1'b1;
                i_req = 4'b0000;
            end
            tick;
            checks++;
            if (o_q !== 8'h00) begin
                failures++;
                $display("FAIL reset_q cyc=%0d got=%h exp=00", n, o_q);
            end
            checks++;
            if (o_qb !== 8'hFF) begin
                failures++;
                $display("FAIL reset_qb cyc=%0d got=%h exp=ff", n, o_qb);
            end
            checks++;
            if (o_gnt !== 4'b0000) begin
                failures++;
                $display("FAIL reset_gnt cyc=%0d got=%b exp=0000", n, o_gnt);
            end
            checks++;
            if (o_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid cyc=%0d got=%b exp=0", n, o_valid);
            end
        end
    endtask

    task automatic test_single_requester;
        logic [3:0] exp_gnt;
        do_reset;
        i_data[8 +: 8] = 8'hA5;
        i_req = 4'b0010;
        tick;
        checks++;
        if (o_gnt !== 4'b0010 || o_owner !== 2'd1 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_grant got gnt=%b own=%0d v=%b exp gnt=0010 own=1 v=0",
                     o_gnt, o_owner, o_valid);
        end
        for (int n = 0; n < 4; n++) begin
            exp_gnt = (n < 3) ? 4'b0010 : 4'b0000;
            tick;
            checks++;
            if (o_q !== 8'hA5 || o_valid !== 1'b1 || o_gnt !== exp_gnt) begin
                failures++;
                $display("FAIL single_load%0d got q=%h v=%b gnt=%b exp q=a5 v=1 gnt=%b",
                         n, o_q, o_valid, o_gnt, exp_gnt);
            end
        end
        tick;
        checks++;
        if (o_gnt !== 4'b0010 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_regrant got gnt=%b v=%b exp gnt=0010 v=0", o_gnt, o_valid);
        end
    endtask

    task automatic test_round_robin;
        int         order [5];
        logic [3:0] exp_gnt;
        logic [3:0] exp_gnt_n;
        logic [7:0] exp_q;
        order = '{0, 1, 2, 3, 0};
        do_reset;
        i_data = {8'h13, 8'h12, 8'h11, 8'h10};
        i_req  = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_gnt = 4'b0001 << order[g];
            exp_q   = 8'(8'h10 + order[g]);
            tick;
            checks++;
            if (o_gnt !== exp_gnt || o_owner !== 2'(order[g]) || o_valid !== 1'b0) begin
                failures++;
                $display("FAIL rr_grant%0d got gnt=%b own=%0d v=%b exp gnt=%b own=%0d v=0",
                         g, o_gnt, o_owner, o_valid, exp_gnt, order[g]);
            end
            for (int n = 0; n < 4; n++) begin
                exp_gnt_n = (n < 3) ? exp_gnt : 4'b0000;
                tick;
                checks++;
                if (o_q !== exp_q || o_qb !== ~exp_q || o_valid !== 1'b1 || o_gnt !== exp_gnt_n) begin
                    failures++;
                    $display("FAIL rr_load%0d_%0d got q=%h qb=%h v=%b gnt=%b exp q=%h v=1 gnt=%b",
                             g, n, o_q, o_qb, o_valid, o_gnt, exp_q, exp_gnt_n);
                end
            end
        end
    endtask

    task automatic test_early_release;
        int vcount;
        do_reset;
        i_data[16 +: 8] = 8'h5C;
        i_req = 4'b0100;
        tick;
        checks++;
        if (o_gnt !== 4'b0100) begin
            failures++;
            $display("FAIL early_grant got=%b exp=0100", o_gnt);
        end
        vcount = 0;
        for (int n = 0; n < 2; n++) begin
            i_data[0 +: 8] = 8'(8'h30 + n);
            tick;
            if (o_valid === 1'b1) vcount++;
            checks++;
            if (o_q !== 8'h5C) begin
                failures++;
                $display("FAIL early_q%0d got=%h exp=5c", n, o_q);
            end
        end
        i_req = 4'b0000;
        tick;
        if (o_valid === 1'b1) vcount++;
        checks++;
        if (o_gnt !== 4'b0000) begin
            failures++;
            $display("FAIL early_drop_gnt got=%b exp=0000", o_gnt);
        end
        checks++;
        if (vcount !== 2) begin
            failures++;
            $display("FAIL early_valid_count got=%0d exp=2", vcount);
        end
        i_data[24 +: 8] = 8'h77;
        i_data[0 +: 8]  = 8'h66;
        i_req = 4'b1001;
        tick;
        checks++;
        if (o_gnt !== 4'b1000 || o_owner !== 2'd3) begin
            failures++;
            $display("FAIL early_next_ptr got gnt=%b own=%0d exp gnt=1000 own=3", o_gnt, o_owner);
        end
        for (int n = 0; n < 4; n++) tick;
        checks++;
        if (o_q !== 8'h77 || o_gnt !== 4'b0000) begin
            failures++;
            $display("FAIL owner3_done got q=%h gnt=%b exp q=77 gnt=0000", o_q, o_gnt);
        end
        tick;
        checks++;
        if (o_gnt !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_grant got=%b exp=0001", o_gnt);
        end
    endtask

    task automatic test_mid_reset;
        do_reset;
        i_data[8 +: 8]  = 8'h21;
        i_data[16 +: 8] = 8'h42;
        i_req = 4'b0010;
        tick;
        tick;
        i_req = 4'b0000;
        tick;
        i_req = 4'b0100;
        tick;
        checks++;
        if (o_gnt !== 4'b0100) begin
            failures++;
            $display("FAIL midrst_grant got=%b exp=0100", o_gnt);
        end
        tick;
        checks++;
        if (o_q !== 8'h42 || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_load1 got q=%h v=%b exp q=42 v=1", o_q, o_valid);
        end
        reset = 1'b0;
        tick;
        checks++;
        if (o_gnt !== 4'b0000 || o_q !== 8'h00 || o_qb !== 8'hFF ||
            o_valid !== 1'b0 || o_owner !== 2'd0) begin
            failures++;
            $display("FAIL midrst_state got gnt=%b q=%h qb=%h v=%b own=%0d exp 0000/00/ff/0/0",
                     o_gnt, o_q, o_qb, o_valid, o_owner);
        end
        reset = 1'b1;
        i_req = 4'b1111;
        tick;
        checks++;
        if (o_gnt !== 4'b0001) begin
            failures++;
            $display("FAIL midrst_restart got=%b exp=0001", o_gnt);
        end
    endtask

`ifdef PES_DFF_ARB_LOCK_EN
    task automatic test_lock;
        do_reset;
        i_data[0 +: 8] = 8'h9E;
        i_lock = 1'b1;
        i_req  = 4'b0001;
        tick;
        checks++;
        if (o_gnt !== 4'b0001) begin
            failures++;
            $display("FAIL lock_grant got=%b exp=0001", o_gnt);
        end
        for (int n = 0; n < 10; n++) begin
            tick;
            checks++;
            if (o_valid !== 1'b1 || o_gnt !== 4'b0001 || o_q !== 8'h9E) begin
                failures++;
                $display("FAIL lock_hold%0d got v=%b gnt=%b q=%h exp v=1 gnt=0001 q=9e",
                         n, o_valid, o_gnt, o_q);
            end
        end
        i_lock = 1'b0;
        tick;
        checks++;
        if (o_valid !== 1'b1 || o_gnt !== 4'b0000) begin
            failures++;
            $display("FAIL lock_release got v=%b gnt=%b exp v=1 gnt=0000", o_valid, o_gnt);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        i_req    = 4'b0000;
        i_data   = 32'h0;
`ifdef PES_DFF_ARB_LOCK_EN
        i_lock   = 1'b0;
`endif
        test_reset;
        test_single_requester;
        test_round_robin;
        test_early_release;
        test_mid_reset;
`ifdef PES_DFF_ARB_LOCK_EN
        test_lock;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
